// File: rtl/nand_page_write_feeder_pkg.sv
// Shared constants and FSM encoding for the NAND page-write feeder.
// Contents: page/block geometry, row limits, retry limit, row-error and
// program-status codes from the write core, feeder FSM state type.
package nand_page_write_feeder_pkg;

  localparam int          PAGE_BYTES      = 2048;
  localparam int          PAGE_AW         = 11;
  localparam int          PAGES_PER_BLOCK = 64;
  localparam logic [23:0] MAX_ROW         = 24'h03FFFF;
  localparam int          MAX_RETRY       = 3;

  localparam logic [1:0]  ROW_ERR_GOOD    = 2'd1;
  localparam logic [1:0]  ROW_ERR_BAD     = 2'd2;
  localparam logic [1:0]  WR_OK           = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_BUF = 3'd1,
    ST_REQ      = 3'd2,
    ST_RUN      = 3'd3,
    ST_CHECK    = 3'd4,
    ST_SKIP     = 3'd5
  } state_t;

endpackage

// File: rtl/nand_page_write_feeder_if.sv
// Byte-stream input and write-core handshake of the page-write feeder.
//   in_data/in_valid/in_ready      : upstream byte stream (ready/valid)
//   en_write_page/end_write_page   : page write request / completion pulse
//   write_data/write_data_cnt      : byte served for the index the core asks for
//   write_addr_row                 : row of the current page write
//   write_addr_row_error           : 0 unchecked, 1 good block, 2 bad block
//   write_success                  : 0 unchecked/fail, 1 program ok
// master = feeder side, slave = stream source + write core side.
interface nand_page_write_feeder_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        en_write_page;
  logic        end_write_page;
  logic [7:0]  write_data;
  logic [13:0] write_data_cnt;
  logic [23:0] write_addr_row;
  logic [1:0]  write_addr_row_error;
  logic [1:0]  write_success;

  modport master (
    input  in_data, in_valid, end_write_page, write_data_cnt,
           write_addr_row_error, write_success,
    output in_ready, en_write_page, write_data, write_addr_row
  );

  modport slave (
    output in_data, in_valid, end_write_page, write_data_cnt,
           write_addr_row_error, write_success,
    input  in_ready, en_write_page, write_data, write_addr_row
  );
endinterface

// File: rtl/nand_page_pingpong_buf.sv
// Ping-pong pair of page buffers.
//   clk, rst      : clock, synchronous active-high reset
//   clear         : drop all buffered data (session start)
//   wr_en/wr_data : accept one byte into the fill buffer
//   drain_done    : current drain buffer consumed; free it and swap drain side
//   rd_idx/rd_data: combinational read of the drain buffer
//   fill_full     : the buffer currently being filled is full
//   drain_full    : the buffer currently being drained holds a complete page
module nand_page_pingpong_buf #(
  parameter int DEPTH = nand_page_write_feeder_pkg::PAGE_BYTES,
  parameter int AW    = nand_page_write_feeder_pkg::PAGE_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          drain_done,
  input  logic [AW-1:0] rd_idx,
  output logic [7:0]    rd_data,
  output logic          fill_full,
  output logic          drain_full
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [7:0]    mem [0:1][0:DEPTH-1];
  logic [AW-1:0] fill_ptr;
  logic          fill_sel;
  logic          drain_sel;
  logic [1:0]    full;

  // Data arrays carry no reset; clearing the full flags discards content.
  always_ff @(posedge clk) begin
    if (wr_en) mem[fill_sel][fill_ptr] <= wr_data;
  end

  // Wrap and drain_done always touch different flag bits: a byte is only
  // accepted into a non-full buffer, and only a full buffer is drained.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      fill_ptr  <= '0;
      fill_sel  <= 1'b0;
      drain_sel <= 1'b0;
      full      <= 2'b00;
    end else begin
      if (wr_en) begin
        fill_ptr <= (fill_ptr == LAST) ? '0 : fill_ptr + 1'b1;
        if (fill_ptr == LAST) begin
          full[fill_sel] <= 1'b1;
          fill_sel       <= ~fill_sel;
        end
      end
      if (drain_done) begin
        full[drain_sel] <= 1'b0;
        drain_sel       <= ~drain_sel;
      end
    end
  end

  assign rd_data    = mem[drain_sel][rd_idx];
  assign fill_full  = full[fill_sel];
  assign drain_full = full[drain_sel];

endmodule

// File: rtl/nand_page_write_feeder.sv
// Page-write feeder: buffers a byte stream into ping-pong page buffers, requests
// page writes from the write core, advances the row, skips bad/failed blocks.
//   clk, rst      : 24 MHz clock, synchronous active-high reset
//   start         : pulse, begin session at row_start (ignored while busy or faulted)
//   stop          : pulse, finish pending full pages then return to idle
//   bus           : stream + write-core handshake (master modport)
//   busy          : session active
//   fault         : sticky retry-limit / row-range fault, cleared by rst only
//   pages_written : successfully programmed pages (wraps)
//
// state    | meaning
// IDLE     | no session; waits for start
// WAIT_BUF | waits for a full drain buffer, or leaves on pending stop
// REQ      | raises en_write_page for the current row
// RUN      | write core busy; leaves on bad block or end_write_page
// CHECK    | one cycle to sample write_success
// SKIP     | move row to next block start, count retry, re-request same page
module nand_page_write_feeder
  import nand_page_write_feeder_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [23:0]                   row_start,
  input  logic                          stop,
  nand_page_write_feeder_if.master      bus,
  output logic                          busy,
  output logic                          fault,
  output logic [15:0]                   pages_written
);

  localparam int          RETRY_W    = $clog2(MAX_RETRY + 1);
  localparam logic [23:0] BLOCK_MASK = 24'(PAGES_PER_BLOCK - 1);

  state_t               state_q, state_d;
  logic [23:0]          row_q, row_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 fault_q, fault_d;
  logic [15:0]          pages_q, pages_d;
  logic                 stop_q, stop_d;
  logic                 buf_clear, drain_done;
  logic                 fill_full, drain_full;
  logic                 wr_en;
  logic [7:0]           rd_data;
  logic [24:0]          skip_row;
  logic [RETRY_W-1:0]   retry_inc;

  assign busy            = (state_q != ST_IDLE);
  assign fault           = fault_q;
  assign pages_written   = pages_q;
  assign bus.in_ready    = busy & ~fault_q & ~fill_full;
  assign bus.en_write_page  = (state_q == ST_REQ) || (state_q == ST_RUN);
  assign bus.write_addr_row = row_q;
  assign bus.write_data  = (|bus.write_data_cnt[13:PAGE_AW]) ? 8'hFF : rd_data;
  assign wr_en           = bus.in_valid & bus.in_ready;

  nand_page_pingpong_buf #(
    .DEPTH (PAGE_BYTES),
    .AW    (PAGE_AW)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .clear      (buf_clear),
    .wr_en      (wr_en),
    .wr_data    (bus.in_data),
    .drain_done (drain_done),
    .rd_idx     (bus.write_data_cnt[PAGE_AW-1:0]),
    .rd_data    (rd_data),
    .fill_full  (fill_full),
    .drain_full (drain_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      retry_q <= '0;
      fault_q <= 1'b0;
      pages_q <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      retry_q <= retry_d;
      fault_q <= fault_d;
      pages_q <= pages_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    retry_d    = retry_q;
    fault_d    = fault_q;
    pages_d    = pages_q;
    stop_d     = stop_q;
    buf_clear  = 1'b0;
    drain_done = 1'b0;
    skip_row   = {1'b0, row_q | BLOCK_MASK} + 25'd1;
    retry_inc  = retry_q + 1'b1;

    if (stop && (state_q != ST_IDLE)) stop_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        if (start && !fault_q) begin
          row_d     = row_start;
          retry_d   = '0;
          buf_clear = 1'b1;
          state_d   = ST_WAIT_BUF;
        end
      end
      ST_WAIT_BUF: begin
        if (drain_full)  state_d = ST_REQ;
        else if (stop_q) state_d = ST_IDLE;
      end
      ST_REQ: state_d = ST_RUN;
      ST_RUN: begin
        if (bus.write_addr_row_error == ROW_ERR_BAD) state_d = ST_SKIP;
        else if (bus.end_write_page)                 state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (bus.write_success == WR_OK) begin
          drain_done = 1'b1;
          pages_d    = pages_q + 16'd1;
          retry_d    = '0;
          // The page is done; only the following page needs a legal row.
          if (row_q == MAX_ROW) begin
            fault_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            row_d   = row_q + 24'd1;
            state_d = ST_WAIT_BUF;
          end
        end else begin
          state_d = ST_SKIP;
        end
      end
      ST_SKIP: begin
        if ((retry_inc == RETRY_W'(MAX_RETRY)) || (skip_row > {1'b0, MAX_ROW})) begin
          fault_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          row_d   = skip_row[23:0];
          retry_d = retry_inc;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_nand_page_write_feeder.sv
// Directed bench for nand_page_write_feeder: stream source and write-core
// model driven from tasks on the falling edge, outputs sampled there too.
module tb_nand_page_write_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [23:0] row_start;
  logic        busy;
  logic        fault;
  logic [15:0] pages_written;
  int          n_cmp = 0;
  int          n_err = 0;

  nand_page_write_feeder_if bus ();

  nand_page_write_feeder dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .row_start     (row_start),
    .stop          (stop),
    .bus           (bus),
    .busy          (busy),
    .fault         (fault),
    .pages_written (pages_written)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_start(input logic [23:0] r);
    start = 1'b1;
    row_start = r;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams n bytes (value = index mod 256); gives up on reset, idle or budget.
  task automatic feed(input int n);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 20000 && !rst && busy) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = sent[7:0];
      if (bus.in_ready) sent++;
      guard++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Returns one cycle after en_write_page is seen, so the DUT is in RUN.
  task automatic wait_en(input string tag);
    int guard = 0;
    while (!bus.en_write_page && guard < 12000) begin
      @(negedge clk);
      guard++;
    end
    check_eq(tag, 32'(bus.en_write_page), 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_byte(input logic [13:0] cnt, input logic [7:0] exp, input string tag);
    bus.write_data_cnt = cnt;
    #1;
    check_eq(tag, 32'(bus.write_data), 32'(exp));
  endtask

  task automatic end_page(input logic [1:0] ok, input string tag);
    bus.write_success  = ok;
    bus.end_write_page = 1'b1;
    @(negedge clk);
    bus.end_write_page = 1'b0;
    check_eq(tag, 32'(bus.en_write_page), 32'd0);
    @(negedge clk);
    bus.write_success = 2'd0;
  endtask

  initial begin
    int en_hi;
    rst = 1'b1; start = 1'b0; stop = 1'b0; row_start = '0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.end_write_page = 1'b0;
    bus.write_data_cnt = '0; bus.write_addr_row_error = 2'd1; bus.write_success = 2'd0;
    @(negedge clk);
    do_reset();

    // reset state
    check_eq("rst_en",    32'(bus.en_write_page), 32'd0);
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    check_eq("rst_pages", 32'(pages_written), 32'd0);
    check_eq("rst_row",   32'(bus.write_addr_row), 32'd0);
    check_eq("rst_ready", 32'(bus.in_ready), 32'd0);

    // two good pages at 0x40, 0x41; start while busy ignored; stop ends session
    do_start(24'h40);
    fork
      feed(4096);
      begin
        wait_en("t1_en0");
        check_eq("t1_row0", 32'(bus.write_addr_row), 32'h40);
        chk_byte(14'd5,    8'h05, "t1_b5");
        chk_byte(14'd300,  8'h2C, "t1_b300");
        chk_byte(14'd2046, 8'hFE, "t1_b2046");
        end_page(2'd1, "t1_drop0");
        start = 1'b1; row_start = 24'h999;
        @(negedge clk);
        start = 1'b0;
        wait_en("t1_en1");
        check_eq("t1_row1", 32'(bus.write_addr_row), 32'h41);
        chk_byte(14'd5, 8'h05, "t1_p1b5");
        end_page(2'd1, "t1_drop1");
        check_eq("t1_pages", 32'(pages_written), 32'd2);
      end
    join
    check_eq("t1_busy", 32'(busy), 32'd1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t1_stop_busy", 32'(busy), 32'd0);

    // bad block at 0x80 -> retry at 0xC0 with same data
    do_reset();
    do_start(24'h80);
    feed(2048);
    wait_en("t2_en0");
    check_eq("t2_row0", 32'(bus.write_addr_row), 32'h80);
    bus.write_addr_row_error = 2'd2;
    @(negedge clk);
    bus.write_addr_row_error = 2'd1;
    check_eq("t2_drop", 32'(bus.en_write_page), 32'd0);
    wait_en("t2_en1");
    check_eq("t2_row1", 32'(bus.write_addr_row), 32'hC0);
    check_eq("t2_pages0", 32'(pages_written), 32'd0);
    chk_byte(14'd5,   8'h05, "t2_b5");
    chk_byte(14'd300, 8'h2C, "t2_b300");
    end_page(2'd1, "t2_end");
    check_eq("t2_pages1", 32'(pages_written), 32'd1);

    // three program failures -> fault
    do_reset();
    do_start(24'h100);
    feed(2048);
    wait_en("t3_en0");
    check_eq("t3_row0", 32'(bus.write_addr_row), 32'h100);
    end_page(2'd0, "t3_f0");
    wait_en("t3_en1");
    check_eq("t3_row1", 32'(bus.write_addr_row), 32'h140);
    end_page(2'd0, "t3_f1");
    wait_en("t3_en2");
    check_eq("t3_row2", 32'(bus.write_addr_row), 32'h180);
    end_page(2'd0, "t3_f2");
    @(negedge clk);
    check_eq("t3_fault", 32'(fault), 32'd1);
    check_eq("t3_busy",  32'(busy), 32'd0);
    check_eq("t3_ready", 32'(bus.in_ready), 32'd0);
    check_eq("t3_pages", 32'(pages_written), 32'd0);
    do_start(24'h0);
    @(negedge clk);
    check_eq("t3_sticky_busy", 32'(busy), 32'd0);

    // last row: one page ok, next page faults with no request
    do_reset();
    do_start(24'h03FFFF);
    fork
      feed(4096);
      begin
        wait_en("t4_en0");
        check_eq("t4_row0", 32'(bus.write_addr_row), 32'h03FFFF);
        end_page(2'd1, "t4_end");
        en_hi = 0;
        repeat (100) begin
          @(negedge clk);
          if (bus.en_write_page) en_hi++;
        end
        check_eq("t4_no_en", 32'(en_hi), 32'd0);
      end
    join
    check_eq("t4_fault", 32'(fault), 32'd1);
    check_eq("t4_busy",  32'(busy), 32'd0);
    check_eq("t4_pages", 32'(pages_written), 32'd1);

    // spare area reads; fill during RUN; in_ready low only with both full
    do_reset();
    do_start(24'h200);
    feed(2048);
    wait_en("t5_en0");
    check_eq("t5_ready_run", 32'(bus.in_ready), 32'd1);
    feed(2048);
    check_eq("t5_ready_full", 32'(bus.in_ready), 32'd0);
    check_eq("t5_en_held",    32'(bus.en_write_page), 32'd1);
    chk_byte(14'd2048, 8'hFF, "t5_sp2048");
    chk_byte(14'd2111, 8'hFF, "t5_sp2111");
    chk_byte(14'd2046, 8'hFE, "t5_b2046");
    chk_byte(14'd0,    8'h00, "t5_b0");
    end_page(2'd1, "t5_end0");
    check_eq("t5_ready_free", 32'(bus.in_ready), 32'd1);
    wait_en("t5_en1");
    check_eq("t5_row1", 32'(bus.write_addr_row), 32'h201);
    chk_byte(14'd5, 8'h05, "t5_p1b5");
    end_page(2'd1, "t5_end1");
    check_eq("t5_pages", 32'(pages_written), 32'd2);

    // reset mid-RUN, then a fresh session
    do_reset();
    do_start(24'h300);
    fork
      feed(4096);
      begin
        wait_en("t6_en0");
        end_page(2'd1, "t6_end0");
        wait_en("t6_en1");
        check_eq("t6_pages1", 32'(pages_written), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_en",    32'(bus.en_write_page), 32'd0);
        check_eq("t6_busy",  32'(busy), 32'd0);
        check_eq("t6_pages", 32'(pages_written), 32'd0);
        rst = 1'b0;
      end
    join
    do_start(24'h400);
    feed(2048);
    wait_en("t6_en2");
    check_eq("t6_row2", 32'(bus.write_addr_row), 32'h400);
    chk_byte(14'd5, 8'h05, "t6_b5");
    end_page(2'd1, "t6_end2");
    check_eq("t6_pages2", 32'(pages_written), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
